// File: rtl/l1d_assoc_cache_if.sv
// Load/store and LLC channels of the associative L1-D.
// slave = cache side, master = LSU plus LLC side.
interface l1d_assoc_cache_if #(
  parameter int DATA_SIZE = 512
);
  logic [63:0]          S_R_ADDR;
  logic                 S_R_ADDR_VALID;
  logic                 S_R_READY;
  logic [DATA_SIZE-1:0] S_R_DATA;
  logic                 S_R_DATA_VALID;
  logic [63:0]          S_W_ADDR;
  logic [63:0]          S_W_DATA;
  logic                 S_W_VALID;
  logic                 S_W_READY;
  logic                 S_W_COMPLETE;
  logic [63:0]          L2_S_R_ADDR;
  logic                 L2_S_R_ADDR_VALID;
  logic [DATA_SIZE-1:0] L2_S_R_DATA;
  logic                 L2_S_R_DATA_VALID;
  logic [63:0]          L2_S_W_ADDR;
  logic [DATA_SIZE-1:0] L2_S_W_DATA;
  logic                 L2_S_W_VALID;
  logic                 L2_S_W_READY;
  logic                 L2_S_W_COMPLETE;

  modport slave (
    input  S_R_ADDR, S_R_ADDR_VALID,
    input  S_W_ADDR, S_W_DATA, S_W_VALID,
    input  L2_S_R_DATA, L2_S_R_DATA_VALID,
    input  L2_S_W_READY, L2_S_W_COMPLETE,
    output S_R_READY, S_R_DATA, S_R_DATA_VALID,
    output S_W_READY, S_W_COMPLETE,
    output L2_S_R_ADDR, L2_S_R_ADDR_VALID,
    output L2_S_W_ADDR, L2_S_W_DATA, L2_S_W_VALID
  );

  modport master (
    output S_R_ADDR, S_R_ADDR_VALID,
    output S_W_ADDR, S_W_DATA, S_W_VALID,
    output L2_S_R_DATA, L2_S_R_DATA_VALID,
    output L2_S_W_READY, L2_S_W_COMPLETE,
    input  S_R_READY, S_R_DATA, S_R_DATA_VALID,
    input  S_W_READY, S_W_COMPLETE,
    input  L2_S_R_ADDR, L2_S_R_ADDR_VALID,
    input  L2_S_W_ADDR, L2_S_W_DATA, L2_S_W_VALID
  );
endinterface

// File: rtl/l1d_assoc_cache.sv
// Set-associative write-back, write-allocate L1-D
// with true-LRU ages and one outstanding request.
module l1d_assoc_cache #(
  parameter int LINE_COUNT     = 64,
  parameter int WAYS           = 4,
  parameter int BYTES_PER_LINE = 64,
  parameter int INDEX_SIZE     = $clog2(LINE_COUNT),
  parameter int OFFSET_SIZE    = $clog2(BYTES_PER_LINE),
  parameter int TAG_SIZE       = 64 - INDEX_SIZE - OFFSET_SIZE,
  parameter int DATA_SIZE      = 8 * BYTES_PER_LINE
) (
  input logic          clk,
  input logic          reset,
  l1d_assoc_cache_if.slave bus
);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    IDLE, EVICT_REQ, EVICT_WAIT, FILL, RESPOND
  } state_t;

  typedef logic [DATA_SIZE-1:0] line_t;

  line_t               data_q  [LINE_COUNT][WAYS];
  logic [TAG_SIZE-1:0] tag_q   [LINE_COUNT][WAYS];
  logic                valid_q [LINE_COUNT][WAYS];
  logic                dirty_q [LINE_COUNT][WAYS];
  logic [WAY_W-1:0]    age_q   [LINE_COUNT][WAYS];

  state_t           state;
  logic [63:0]      addr_q;
  logic [63:0]      wdata_q;
  logic             wr_q;
  logic [WAY_W-1:0] way_q;
  line_t            rsp_q;

  logic [63:0]           lk_addr;
  logic [INDEX_SIZE-1:0] idx;
  logic [TAG_SIZE-1:0]   tag;
  logic                  wr_sel;
  logic                  accept;
  logic                  hit;
  logic [WAY_W-1:0]      hit_way;
  logic [WAY_W-1:0]      vic;
  logic                  found_inv;
  logic                  fill_dv;
  logic                  age_upd;
  logic [WAY_W-1:0]      acc_way;

  function automatic line_t merge(
    input line_t l,
    input logic [63:0] a,
    input logic [63:0] w
  );
    int sel;
    sel = int'(a[OFFSET_SIZE-1:0] >> 3);
    merge = l;
    merge[sel*64 +: 64] = w;
  endfunction

  // In IDLE look up the incoming request, otherwise the latched one.
  always_comb begin
    wr_sel  = bus.S_W_VALID;
    lk_addr = addr_q;
    if (state == IDLE)
      lk_addr = wr_sel ? bus.S_W_ADDR : bus.S_R_ADDR;
    idx = lk_addr[OFFSET_SIZE+INDEX_SIZE-1:OFFSET_SIZE];
    tag = lk_addr[63:OFFSET_SIZE+INDEX_SIZE];
    accept = (state == IDLE) &&
             (bus.S_W_VALID || bus.S_R_ADDR_VALID);
    fill_dv = (state == FILL) && bus.L2_S_R_DATA_VALID;
  end

  // Tag match and victim choice: first invalid way, else the LRU way.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    found_inv = 1'b0;
    vic       = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!found_inv && !valid_q[idx][w]) begin
        found_inv = 1'b1;
        vic       = WAY_W'(w);
      end
    end
    if (!found_inv) begin
      for (int w = 0; w < WAYS; w++)
        if (age_q[idx][w] == WAY_W'(WAYS - 1))
          vic = WAY_W'(w);
    end
    age_upd = (accept && hit) || fill_dv;
    acc_way = (state == IDLE) ? hit_way : way_q;
  end

  // Line payload and tags; qualified by valid so no reset needed.
  always_ff @(posedge clk) begin
    if (accept && hit && wr_sel)
      data_q[idx][hit_way] <= merge(data_q[idx][hit_way],
                                    lk_addr, bus.S_W_DATA);
    if (fill_dv) begin
      data_q[idx][way_q] <= wr_q ?
        merge(bus.L2_S_R_DATA, addr_q, wdata_q) :
        bus.L2_S_R_DATA;
      tag_q[idx][way_q] <= tag;
    end
  end

  // Control FSM plus valid, dirty and age state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      way_q   <= '0;
      rsp_q   <= '0;
      for (int s = 0; s < LINE_COUNT; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w]   <= WAY_W'(w);
        end
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= lk_addr;
            wdata_q <= bus.S_W_DATA;
            wr_q    <= wr_sel;
            if (hit) begin
              way_q <= hit_way;
              if (wr_sel) dirty_q[idx][hit_way] <= 1'b1;
              else        rsp_q <= data_q[idx][hit_way];
              state <= RESPOND;
            end else begin
              way_q <= vic;
              state <= (valid_q[idx][vic] && dirty_q[idx][vic]) ?
                       EVICT_REQ : FILL;
            end
          end
        end
        EVICT_REQ: begin
          if (bus.L2_S_W_READY) state <= EVICT_WAIT;
        end
        EVICT_WAIT: begin
          if (bus.L2_S_W_COMPLETE) begin
            dirty_q[idx][way_q] <= 1'b0;
            state <= FILL;
          end
        end
        FILL: begin
          if (bus.L2_S_R_DATA_VALID) begin
            valid_q[idx][way_q] <= 1'b1;
            dirty_q[idx][way_q] <= wr_q;
            if (!wr_q) rsp_q <= bus.L2_S_R_DATA;
            state <= RESPOND;
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (age_upd) begin
        for (int j = 0; j < WAYS; j++)
          if (age_q[idx][j] < age_q[idx][acc_way])
            age_q[idx][j] <= age_q[idx][j] + 1'b1;
        age_q[idx][acc_way] <= '0;
      end
    end
  end

  logic rdy, rsp, ev, fl;
  assign rdy = (state == IDLE) && !reset;
  assign rsp = (state == RESPOND);
  assign ev  = (state == EVICT_REQ);
  assign fl  = (state == FILL);

  assign bus.S_R_READY      = rdy;
  assign bus.S_W_READY      = rdy;
  assign bus.S_R_DATA_VALID = rsp && !wr_q;
  assign bus.S_W_COMPLETE   = rsp && wr_q;
  assign bus.S_R_DATA       = (rsp && !wr_q) ? rsp_q : '0;

  assign bus.L2_S_W_VALID = ev;
  assign bus.L2_S_W_ADDR  = ev ?
    {tag_q[idx][way_q], idx, {OFFSET_SIZE{1'b0}}} : '0;
  assign bus.L2_S_W_DATA  = ev ? data_q[idx][way_q] : '0;

  assign bus.L2_S_R_ADDR_VALID = fl;
  assign bus.L2_S_R_ADDR = fl ?
    {tag, idx, {OFFSET_SIZE{1'b0}}} : '0;
endmodule

// File: tb/tb_l1d_assoc_cache.sv
// Directed bench for l1d_assoc_cache with a
// response scoreboard and an inline LLC responder.
module tb_l1d_assoc_cache;
  typedef logic [511:0] line_t;
  typedef struct {
    bit    wr;
    line_t data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];

  l1d_assoc_cache_if #(.DATA_SIZE(512)) bus();

  l1d_assoc_cache #(
    .LINE_COUNT(64),
    .WAYS(4),
    .BYTES_PER_LINE(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [511:0] got,
                       input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic line_t pat(input logic [63:0] a);
    line_t l;
    for (int i = 0; i < 8; i++)
      l[i*64 +: 64] = {a[31:0], 32'hC0DE0000 | 32'(i)};
    return l;
  endfunction

  function automatic line_t setw(input line_t l, input int s,
                                 input logic [63:0] w);
    line_t r;
    r = l;
    r[s*64 +: 64] = w;
    return r;
  endfunction

  // Monitor: every response pulse pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (bus.S_R_DATA_VALID || bus.S_W_COMPLETE)) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rv=%0b wc=%0b expected none",
                 bus.S_R_DATA_VALID, bus.S_W_COMPLETE);
      end else begin
        e = sb.pop_front();
        check("rsp_kind", bus.S_W_COMPLETE, e.wr);
        if (!e.wr) check("rsp_data", bus.S_R_DATA, e.data);
      end
    end
  end

  // One request from IDLE, acting as LLC when it misses.
  task automatic req(input bit wr, input logic [63:0] a,
                     input logic [63:0] wd, input bit miss,
                     input bit dirty, input logic [63:0] vaddr,
                     input line_t vline, input line_t fline,
                     input line_t exp);
    exp_t e;
    e.wr = wr;
    e.data = exp;
    sb.push_back(e);
    check("req_ready", wr ? bus.S_W_READY : bus.S_R_READY, 1'b1);
    if (wr) begin
      bus.S_W_ADDR = a;
      bus.S_W_DATA = wd;
      bus.S_W_VALID = 1'b1;
    end else begin
      bus.S_R_ADDR = a;
      bus.S_R_ADDR_VALID = 1'b1;
    end
    @(negedge clk);
    bus.S_W_VALID = 1'b0;
    bus.S_R_ADDR_VALID = 1'b0;
    if (!miss) begin
      check("hit_t1_pulse",
            wr ? bus.S_W_COMPLETE : bus.S_R_DATA_VALID, 1'b1);
      check("hit_no_l2",
            {bus.L2_S_R_ADDR_VALID, bus.L2_S_W_VALID}, 2'b00);
    end else begin
      if (dirty) begin
        check("ev_valid", bus.L2_S_W_VALID, 1'b1);
        check("ev_addr", bus.L2_S_W_ADDR, vaddr);
        check("ev_data", bus.L2_S_W_DATA, vline);
        check("ev_no_fill", bus.L2_S_R_ADDR_VALID, 1'b0);
        repeat (2) begin
          @(negedge clk);
          check("ev_hold", bus.L2_S_W_VALID, 1'b1);
        end
        bus.L2_S_W_READY = 1'b1;
        @(negedge clk);
        bus.L2_S_W_READY = 1'b0;
        check("ev_wait_idle",
              {bus.L2_S_W_VALID, bus.L2_S_R_ADDR_VALID}, 2'b00);
        @(negedge clk);
        check("ev_wait_nofill", bus.L2_S_R_ADDR_VALID, 1'b0);
        bus.L2_S_W_COMPLETE = 1'b1;
        @(negedge clk);
        bus.L2_S_W_COMPLETE = 1'b0;
      end else begin
        check("clean_no_wb", bus.L2_S_W_VALID, 1'b0);
      end
      check("fill_valid", bus.L2_S_R_ADDR_VALID, 1'b1);
      check("fill_addr", bus.L2_S_R_ADDR, a & ~64'h3F);
      repeat (2) begin
        @(negedge clk);
        check("fill_hold", bus.L2_S_R_ADDR_VALID, 1'b1);
      end
      bus.L2_S_R_DATA = fline;
      bus.L2_S_R_DATA_VALID = 1'b1;
      @(negedge clk);
      bus.L2_S_R_DATA_VALID = 1'b0;
      check("miss_f1_pulse",
            wr ? bus.S_W_COMPLETE : bus.S_R_DATA_VALID, 1'b1);
    end
    @(negedge clk);
    check("back_idle", bus.S_R_READY, 1'b1);
    check("rdata_zero", bus.S_R_DATA, '0);
  endtask

  task automatic rd_hit(input logic [63:0] a, input line_t exp);
    req(1'b0, a, 64'h0, 1'b0, 1'b0, 64'h0, '0, '0, exp);
  endtask

  task automatic rd_miss(input logic [63:0] a);
    req(1'b0, a, 64'h0, 1'b1, 1'b0, 64'h0, '0, pat(a), pat(a));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_ready", {bus.S_R_READY, bus.S_W_READY}, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_after_rst", bus.S_R_READY, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    line_t a_line;
    bus.S_R_ADDR = '0;
    bus.S_R_ADDR_VALID = 1'b0;
    bus.S_W_ADDR = '0;
    bus.S_W_DATA = '0;
    bus.S_W_VALID = 1'b0;
    bus.L2_S_R_DATA = '0;
    bus.L2_S_R_DATA_VALID = 1'b0;
    bus.L2_S_W_READY = 1'b0;
    bus.L2_S_W_COMPLETE = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_ready", {bus.S_R_READY, bus.S_W_READY}, 2'b00);
    check("rst_l2", {bus.L2_S_R_ADDR_VALID, bus.L2_S_W_VALID}, 2'b00);
    check("rst_rsp", {bus.S_R_DATA_VALID, bus.S_W_COMPLETE}, 2'b00);
    reset = 1'b0;
    #1;
    check("ready_after_rst", bus.S_R_READY, 1'b1);

    a_line = pat(64'h1040);
    rd_miss(64'h1040);
    rd_hit(64'h1040, a_line);
    req(1'b1, 64'h1048, 64'hDEADBEEF, 1'b0, 1'b0, 64'h0,
        '0, '0, '0);
    rd_hit(64'h1040, setw(a_line, 1, 64'hDEADBEEF));

    rd_miss(64'h0000);
    rd_miss(64'h1000);
    rd_miss(64'h2000);
    rd_miss(64'h3000);
    rd_hit(64'h0000, pat(64'h0000));
    rd_miss(64'h4000);
    rd_hit(64'h0000, pat(64'h0000));
    rd_miss(64'h1000);
    rd_hit(64'h3000, pat(64'h3000));

    do_reset();
    req(1'b1, 64'h0000, 64'h55, 1'b1, 1'b0, 64'h0,
        '0, pat(64'h0000), '0);
    rd_miss(64'h1000);
    rd_miss(64'h2000);
    rd_miss(64'h3000);
    req(1'b0, 64'h4000, 64'h0, 1'b1, 1'b1, 64'h0000,
        setw(pat(64'h0000), 0, 64'h55),
        pat(64'h4000), pat(64'h4000));

    e.wr = 1'b1;
    e.data = '0;
    sb.push_back(e);
    e.wr = 1'b0;
    e.data = pat(64'h3000);
    sb.push_back(e);
    bus.S_W_ADDR = 64'h4008;
    bus.S_W_DATA = 64'h1234;
    bus.S_W_VALID = 1'b1;
    bus.S_R_ADDR = 64'h3000;
    bus.S_R_ADDR_VALID = 1'b1;
    @(negedge clk);
    bus.S_W_VALID = 1'b0;
    check("both_write_first", bus.S_W_COMPLETE, 1'b1);
    @(negedge clk);
    check("both_read_pending_ready", bus.S_R_READY, 1'b1);
    @(negedge clk);
    bus.S_R_ADDR_VALID = 1'b0;
    check("both_read_second", bus.S_R_DATA_VALID, 1'b1);
    @(negedge clk);
    rd_hit(64'h4000, setw(pat(64'h4000), 1, 64'h1234));

    bus.S_R_ADDR = 64'h5040;
    bus.S_R_ADDR_VALID = 1'b1;
    @(negedge clk);
    bus.S_R_ADDR_VALID = 1'b0;
    check("fill_before_rst", bus.L2_S_R_ADDR_VALID, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_drops_fill", bus.L2_S_R_ADDR_VALID, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    bus.L2_S_R_DATA = pat(64'h5040);
    bus.L2_S_R_DATA_VALID = 1'b1;
    bus.L2_S_W_READY = 1'b1;
    bus.L2_S_W_COMPLETE = 1'b1;
    @(negedge clk);
    bus.L2_S_R_DATA_VALID = 1'b0;
    bus.L2_S_W_READY = 1'b0;
    bus.L2_S_W_COMPLETE = 1'b0;
    repeat (2) @(negedge clk);
    check("late_l2_ignored",
          {bus.L2_S_R_ADDR_VALID, bus.L2_S_W_VALID,
           bus.S_R_DATA_VALID}, 3'b000);
    rd_miss(64'h5040);

    repeat (2) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/l1d_assoc_cache.md
# l1d_assoc_cache

Parametrised set-associative, write-back, write-allocate L1 data cache with true-LRU replacement. It sits between the load/store unit (S_* ports) and the LLC (L2_* ports). It generalises the direct-mapped L1-D to WAYS ways, word-granular stores, and explicit ready/valid handshakes. It supports one outstanding request, with a dirty-victim writeback before each fill.

## Interface
- LINE_COUNT, 64: number of sets; power of 2.
- WAYS, 4: associativity; power of 2, 1..8.
- BYTES_PER_LINE, 64: line size; power of 2, at least 8.
- INDEX_SIZE, OFFSET_SIZE, TAG_SIZE, DATA_SIZE: derived.
  - INDEX_SIZE = clog2(LINE_COUNT).
  - OFFSET_SIZE = clog2(BYTES_PER_LINE).
  - TAG_SIZE = 64-INDEX_SIZE-OFFSET_SIZE.
  - DATA_SIZE = 8*BYTES_PER_LINE.
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  clock.
  - reset  in  1  asynchronous, active-high.
- Read request channel:
  - S_R_ADDR  in  64  read address.
  - S_R_ADDR_VALID  in  1  read request.
  - S_R_READY  out  1  read request accepted when high with VALID.
  - S_R_DATA  out  DATA_SIZE  full line.
  - S_R_DATA_VALID  out  1  one-cycle response pulse.
- Write request channel:
  - S_W_ADDR  in  64  write address.
  - S_W_DATA  in  64  store word.
  - S_W_VALID  in  1  write request.
  - S_W_READY  out  1  write request accepted when high with VALID.
  - S_W_COMPLETE  out  1  one-cycle completion pulse.
- LLC read channel:
  - L2_S_R_ADDR  out  64  line-aligned fill address.
  - L2_S_R_ADDR_VALID  out  1  fill request.
  - L2_S_R_DATA  in  DATA_SIZE  fill data.
  - L2_S_R_DATA_VALID  in  1  fill data valid.
- LLC write channel:
  - L2_S_W_ADDR  out  64  line-aligned victim address.
  - L2_S_W_DATA  out  DATA_SIZE  victim line.
  - L2_S_W_VALID  out  1  writeback request.
  - L2_S_W_READY  in  1  writeback request accepted.
  - L2_S_W_COMPLETE  in  1  writeback done.

## Operation
- **Address fields:**
  - tag = addr[63:OFFSET_SIZE+INDEX_SIZE].
  - index = addr[OFFSET_SIZE+INDEX_SIZE-1:OFFSET_SIZE].
  - Store word slot = addr[OFFSET_SIZE-1:3]; addr[2:0] is ignored.
- **Per-way line state:** valid bit, dirty bit, tag, data, and a clog2(WAYS)-bit age.
  - Age 0 means MRU; age WAYS-1 means LRU.
  - Ages within a set are always a permutation of 0..WAYS-1.
- **FSM states:** IDLE, EVICT_REQ, EVICT_WAIT, FILL, RESPOND.
- **IDLE:**
  - S_R_READY = S_W_READY = 1.
  - If both channels are valid, the write wins; the read stays pending, since its READY does not qualify a transfer.
  - Accepting a request latches its address, its store word, and a read/write flag.
  - **Hit** (a valid way with matching tag):
    - Write hit merges the word into the line and sets dirty.
    - Read hit latches the line into the response register.
    - Age update, then go to RESPOND.
  - **Miss, victim selection:** lowest-numbered invalid way; otherwise the way with age WAYS-1.
    - Dirty victim: go to EVICT_REQ.
    - Otherwise: go to FILL.
- **EVICT_REQ:**
  - L2_S_W_VALID = 1, L2_S_W_ADDR = {victim tag, index, 0}, L2_S_W_DATA = victim data.
  - Hold until L2_S_W_READY, then go to EVICT_WAIT.
- **EVICT_WAIT:**
  - Wait for L2_S_W_COMPLETE, then clear the victim's dirty bit and go to FILL.
- **FILL:**
  - L2_S_R_ADDR_VALID = 1, L2_S_R_ADDR = {tag, index, 0}; held until L2_S_R_DATA_VALID.
  - On data valid, install the line into the victim way: valid=1, tag written.
  - Write miss: merge the store word into the installed line, dirty=1.
  - Read miss: dirty=0, and the installed line goes to the response register.
  - Age update, then go to RESPOND.
- **RESPOND:**
  - Read: pulse S_R_DATA_VALID for one cycle with S_R_DATA.
  - Write: pulse S_W_COMPLETE for one cycle.
  - Then go to IDLE.
- **Age update on access to way w with old age a:**
  - Every way in the set with age < a increments.
  - Way w becomes 0.
- S_R_DATA is the registered response line; it is 0 outside S_R_DATA_VALID.

## Timing
- **Reset (async):**
  - State goes to IDLE; all valid and dirty bits clear.
  - Ages reset to the way number.
  - All outputs are 0, including both READY signals while reset is high.
  - READY rises in the first cycle after deassertion.
- **Reset mid-miss:**
  - L2 valids drop immediately.
  - Any later L2 data, ready or complete responses are ignored.
  - No S_* response is produced.
- **Hit:** accepted at cycle T; response pulse at T+1; READY high again at T+2.
- **Clean miss:**
  - L2_S_R_ADDR_VALID is high from T+1.
  - Fill data valid at cycle F gives a response at F+1.
- **Dirty miss:**
  - L2_S_W_VALID is high from T+1.
  - Fill starts the cycle after L2_S_W_COMPLETE.
- L2 input strobes are ignored outside their matching state.

## Test plan
- **Cold read miss:** after reset, read 0x1040, LLC returns the line pattern A after 3 cycles.
  - Required: L2_S_R_ADDR=0x1040 held high until data.
  - Required: S_R_DATA_VALID pulses one cycle with A.
  - Required: a repeat read 0x1040 hits, with the response at T+1 and no L2 traffic.
- **Write hit:** after the previous case, write 0x1048 with 0xDEADBEEF.
  - Required: S_W_COMPLETE at T+1.
  - Required: a read of 0x1040 returns A with word 1 = 0xDEADBEEF.
- **Associativity and LRU (WAYS=4):**
  - Stimulus: read 0x0000, 0x1000, 0x2000, 0x3000, then re-read 0x0000, then read 0x4000.
  - Required: the 0x4000 fill evicts the 0x1000 way.
  - Required: a re-read of 0x0000 still hits.
- **Dirty eviction:** write 0x0000 with 0x55, fill the set with 0x1000, 0x2000, 0x3000, then read 0x4000.
  - Required: L2_S_W_VALID with ADDR=0x0000 and word 0 = 0x55, held until L2_S_W_READY.
  - Required: the fill is issued only after L2_S_W_COMPLETE.
- **Simultaneous read and write requests:** both valid in the same IDLE cycle.
  - Required: the write is serviced first.
  - Required: the read is accepted on the next IDLE cycle.
- **Reset during FILL:**
  - Required: L2_S_R_ADDR_VALID drops asynchronously.
  - Required: a late L2_S_R_DATA_VALID causes no response.
  - Required: a subsequent read of the same address misses.
